// File: rtl/spad_fill_ctrl.sv
// Scratch-pad fill controller: streams upstream words into consecutive scratch-pad addresses.
// Optional macro SPAD_FILL_LEN_EN adds a fill_len input that selects a shorter fill per pass.
module spad_fill_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 9,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
`ifdef SPAD_FILL_LEN_EN
    input  logic [ADDR_WIDTH:0]   fill_len,
`endif
    output logic                  in_ready,
    output logic                  spad_write_en,
    output logic [ADDR_WIDTH-1:0] spad_write_addr,
    output logic [DATA_WIDTH-1:0] spad_write_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   cnt_reg;
    logic [ADDR_WIDTH-1:0]   last_reg;
    logic                    we_reg;
    logic                    done_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [ADDR_WIDTH-1:0]   start_last;

`ifdef SPAD_FILL_LEN_EN
    localparam logic [ADDR_WIDTH:0] NUM_REGS_L = (ADDR_WIDTH + 1)'(NUM_REGS);

    // Out-of-range lengths fall back to a full pass.
    always_comb begin
        start_last = LAST_ADDR;
        if (fill_len != '0 && fill_len <= NUM_REGS_L)
            start_last = ADDR_WIDTH'(fill_len - 1'b1);
    end
`else
    assign start_last = LAST_ADDR;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= LAST_ADDR;
            we_reg    <= 1'b0;
            done_reg  <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            we_reg   <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= FILL;
                        cnt_reg   <= '0;
                        last_reg  <= start_last;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        we_reg   <= 1'b1;
                        addr_reg <= cnt_reg;
                        data_reg <= in_data;
                        // Counter parks on the last address rather than wrapping.
                        if (cnt_reg == last_reg) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready        = (state_reg == FILL);
    assign busy            = (state_reg != IDLE);
    assign done            = done_reg;
    assign spad_write_en   = we_reg;
    assign spad_write_addr = addr_reg;
    assign spad_write_data = data_reg;

endmodule

// File: tb/tb_spad_fill_ctrl.sv
// Bench for spad_fill_ctrl: fill-length model with per-cycle compare plus directed literal checks.
`timescale 1ns/100ps
module tb_spad_fill_ctrl;
    localparam int DW = 16;
    localparam int NR = 9;
    localparam int AW = $clog2(NR);

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          spad_write_en;
    logic [AW-1:0] spad_write_addr;
    logic [DW-1:0] spad_write_data;
    logic          busy;
    logic          done;
`ifdef SPAD_FILL_LEN_EN
    logic [AW:0]   fill_len;
`endif

    spad_fill_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
`ifdef SPAD_FILL_LEN_EN
        .fill_len(fill_len),
`endif
        .in_ready(in_ready),
        .spad_write_en(spad_write_en),
        .spad_write_addr(spad_write_addr),
        .spad_write_data(spad_write_data),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 = waiting for start, 1 = taking words, 2 = completion cycle.
    int m_phase, m_acc, m_len;
    int e_we, e_done, e_addr, e_data;

    // Writes the scratch pad actually commits (strobe high at a rising edge).
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int cyc = 0;
    int dones, done_addr, done_we, ready_cycles;

    function automatic void chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_acc = 0; m_len = NR;
            e_we = 0; e_done = 0; e_addr = 0; e_data = 0;
            #1;
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_we", int'(spad_write_en), 0);
            chk("rst_addr", int'(spad_write_addr), 0);
            chk("rst_data", int'(spad_write_data), 0);
        end else begin
            cyc++;
            if (spad_write_en) begin
                wr_addr.push_back(int'(spad_write_addr));
                wr_data.push_back(int'(spad_write_data));
                wr_cyc.push_back(cyc);
            end
            if (done) begin
                dones++;
                done_addr = int'(spad_write_addr);
                done_we   = int'(spad_write_en);
            end
            if (in_ready) ready_cycles++;

            e_we = 0; e_done = 0;
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_acc = 0; m_len = NR;
`ifdef SPAD_FILL_LEN_EN
                    if (fill_len != 0 && int'(fill_len) <= NR) m_len = int'(fill_len);
`endif
                end
                1: if (in_valid) begin
                    e_we = 1; e_addr = m_acc; e_data = int'(in_data);
                    m_acc++;
                    if (m_acc == m_len) begin
                        m_phase = 2; e_done = 1;
                    end
                end
                default: m_phase = 0;
            endcase
            #1;
            chk("in_ready", int'(in_ready), int'(m_phase == 1));
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("done", int'(done), e_done);
            chk("write_en", int'(spad_write_en), e_we);
            if (e_we) begin
                chk("write_addr", int'(spad_write_addr), e_addr);
                chk("write_data", int'(spad_write_data), e_data);
            end
        end
    end

    task automatic drive(input bit s, input bit v, input int d);
        @(negedge clk);
        start = s; in_valid = v; in_data = DW'(d);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        dones = 0; done_addr = -1; done_we = 0; ready_cycles = 0;
    endtask

    task automatic fill(input int first_word);
        drive(1, 0, 0);
        for (int i = 0; i < NR; i++) drive(0, 1, first_word + i);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef SPAD_FILL_LEN_EN
        fill_len = (AW + 1)'(NR);
`endif
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Continuous fill of words 1..9.
        clear_log(); fill(1); flush(3);
        chk("t1_count", wr_addr.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk("t1_addr", wr_addr[i], i);
            chk("t1_data", wr_data[i], i + 1);
        end
        chk("t1_span", wr_cyc[8] - wr_cyc[0], 8);
        chk("t1_dones", dones, 1);
        chk("t1_done_addr", done_addr, 8);
        chk("t1_done_we", done_we, 1);
        chk("t1_busy_after", int'(busy), 0);

        // Three-cycle valid gap after word 4.
        clear_log();
        drive(1, 0, 0);
        for (int i = 1; i <= 4; i++) drive(0, 1, i);
        flush(3);
        for (int i = 5; i <= 9; i++) drive(0, 1, i);
        flush(3);
        chk("t2_count", wr_addr.size(), 9);
        chk("t2_addr4", wr_addr[4], 4);
        chk("t2_data4", wr_data[4], 5);
        chk("t2_gap", wr_cyc[4] - wr_cyc[3], 4);
        chk("t2_done_addr", done_addr, 8);

        // Restart attempt mid-fill and surplus valid words.
        clear_log();
        drive(1, 0, 0);
        drive(0, 1, 1); drive(0, 1, 2); drive(1, 1, 3);
        for (int i = 0; i < 12; i++) drive(0, 1, 4 + i);
        flush(3);
        chk("t3_count", wr_addr.size(), 9);
        chk("t3_last_data", wr_data[8], 9);
        chk("t3_ready_cycles", ready_cycles, 9);
        chk("t3_dones", dones, 1);

        // Back-to-back fills; start held through DONE is ignored, taken in the IDLE after.
        clear_log();
        fill(1);
        drive(1, 0, 0); drive(1, 0, 0);
        for (int i = 0; i < NR; i++) drive(0, 1, 'h11 + i);
        flush(3);
        chk("t4_count", wr_addr.size(), 18);
        chk("t4_addr9", wr_addr[9], 0);
        chk("t4_data9", wr_data[9], 'h11);
        chk("t4_turnaround", wr_cyc[9] - wr_cyc[8], 3);
        chk("t4_dones", dones, 2);

        // Asynchronous reset after five accepts.
        clear_log();
        drive(1, 0, 0);
        for (int i = 1; i <= 5; i++) drive(0, 1, i);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_async_we", int'(spad_write_en), 0);
        chk("t5_async_busy", int'(busy), 0);
        chk("t5_async_ready", int'(in_ready), 0);
        chk("t5_async_addr", int'(spad_write_addr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        flush(2);
        chk("t5_committed", wr_addr.size(), 4);
        clear_log(); fill('h21); flush(3);
        chk("t5_new_count", wr_addr.size(), 9);
        chk("t5_new_addr0", wr_addr[0], 0);
        chk("t5_new_data0", wr_data[0], 'h21);

`ifdef SPAD_FILL_LEN_EN
        clear_log(); fill_len = 5'd4; fill(1); flush(3);
        chk("t6_len4_count", wr_addr.size(), 4);
        chk("t6_len4_done_addr", done_addr, 3);
        clear_log(); fill_len = 5'd0; fill(1); flush(3);
        chk("t6_len0_count", wr_addr.size(), 9);
        clear_log(); fill_len = 5'd12; fill(1); flush(3);
        chk("t6_len12_count", wr_addr.size(), 9);
        chk("t6_len12_done_addr", done_addr, 8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
